// File: rtl/hex_display_ctrl.sv
// Valid/ready display-word controller: digit-serial leading-zero scan, then an atomic commit of
// nibbles and output enables for DIGITS hex decoders. Optional bank blink: HEX_DISPLAY_CTRL_BLINK_EN.
module hex_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  wr_lzb,
  input  logic                  wr_blink,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     oe,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]          state;
  logic [IDX_W-1:0]    idx;
  logic                seen_nz;
  logic [DIGITS-1:0]   mask_acc;
  logic [DIGITS-1:0]   en_mask;
  logic [4*DIGITS-1:0] sh_data;
  logic                sh_lzb;

  logic [3:0]          cur_digit;
  logic                blank;
  logic [DIGITS-1:0]   mask_next;
  logic                accept;
  logic                commit;
  logic [DIGITS-1:0]   en_mask_nxt;
  logic                blink_flag_nxt;
  logic                blink_phase_nxt;

  assign wr_ready = (state == IDLE);
  assign busy     = ~wr_ready;
  assign accept   = wr_valid & wr_ready;
  assign commit   = (state == SCAN) && (idx == '0);

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    cur_digit      = sh_data[{idx, 2'b00} +: 4];
    blank          = sh_lzb & ~seen_nz & (cur_digit == 4'h0) & (idx != '0);
    mask_next      = mask_acc;
    mask_next[idx] = ~blank;
  end

  // Bit 0 is forced on so an all-zero word still shows a single "0".
  assign en_mask_nxt = commit ? (mask_next | DIGITS'(1)) : en_mask;

`ifdef HEX_DISPLAY_CTRL_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             blink_flag;
  logic             sh_blink;
  logic             cnt_wrap;

  assign cnt_wrap        = (blink_cnt == CNT_W'(BLINK_DIV - 1));
  assign blink_phase_nxt = blink_phase ^ cnt_wrap;
  assign blink_flag_nxt  = commit ? sh_blink : blink_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_flag  <= 1'b0;
    end else begin
      blink_cnt   <= cnt_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase_nxt;
      blink_flag  <= blink_flag_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) sh_blink <= wr_blink;
  end
`else
  logic unused_blink;
  assign unused_blink    = wr_blink;
  assign blink_flag_nxt  = 1'b0;
  assign blink_phase_nxt = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hex_out <= '0;
      en_mask <= '0;
      oe      <= '0;
    end else begin
      // Built from next-state values so a phase toggle landing on commit applies immediately.
      oe      <= en_mask_nxt & ~{DIGITS{blink_flag_nxt & blink_phase_nxt}};
      en_mask <= en_mask_nxt;
      if (state == IDLE) begin
        if (accept) state <= SCAN;
      end else if (commit) begin
        state   <= IDLE;
        hex_out <= sh_data;
      end
    end
  end

  // NOTE: shadow and scan registers carry no reset; they are always loaded on accept before use,
  // and a reset forces IDLE so a half-scanned word can never be committed.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_data  <= wr_data;
      sh_lzb   <= wr_lzb;
      idx      <= IDX_W'(DIGITS - 1);
      seen_nz  <= 1'b0;
      mask_acc <= '0;
    end else if (state == SCAN) begin
      idx      <= idx - 1'b1;
      seen_nz  <= seen_nz | (cur_digit != 4'h0);
      mask_acc <= mask_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (DIGITS=4, BLINK_DIV=4); follows HEX_DISPLAY_CTRL_BLINK_EN.
module tb_hex_display_ctrl;

  localparam int DIGITS    = 4;
  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        wr_lzb = 1'b0;
  logic        wr_blink = 1'b0;
  logic [15:0] hex_out;
  logic [3:0]  oe;
  logic        busy;

  hex_display_ctrl #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_lzb(wr_lzb), .wr_blink(wr_blink), .hex_out(hex_out), .oe(oe), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  oe;
    logic        chk_oe;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          cyc = 0;
  int          acc_cyc[$];
  logic [15:0] last_hex = '0;
  logic [3:0]  samp[16];

  always @(posedge clk) begin
    cyc++;
    if (!rst && wr_valid && wr_ready) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A digit position stays lit when lzb is off, or when any digit at or above it is nonzero.
  function automatic logic [3:0] model_mask(input logic [15:0] d, input logic lzb);
    logic [3:0] m;
    m = 4'b0001;
    if (!lzb) return 4'b1111;
    for (int i = 1; i < 4; i++)
      if ((d >> (4 * i)) != 16'h0) m[i] = 1'b1;
    return m;
  endfunction

  // Called at the first negedge after acceptance; ends at the negedge where wr_ready is back.
  task automatic wait_commit();
    int lows;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_ready) break;
      lows++;
      check("busy_during_scan", busy, 1);
      check("hex_hold", hex_out, last_hex);
      @(negedge clk);
    end
    check("ready_after_scan", wr_ready, 1);
    check("scan_len", lows, DIGITS);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check("hex_commit", hex_out, e.hex);
    if (e.chk_oe) check("oe_commit", oe, e.oe);
    last_hex = e.hex;
  endtask

  task automatic do_write(input logic [15:0] d, input logic lzb, input logic blink, input logic chk_oe);
    @(negedge clk);
    check("ready_before", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_lzb   = lzb;
    wr_blink = blink;
    sb.push_back('{hex: d, oe: model_mask(d, lzb), chk_oe: chk_oe});
    @(negedge clk);
    wr_valid = 1'b0;
    wait_commit();
    sb_compare();
  endtask

  initial begin
    int a0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_oe", oe, 4'b0000);
    check("rst_hex", hex_out, 16'h0000);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", busy, 0);

    do_write(16'h00A5, 1'b1, 1'b0, 1'b1);
    do_write(16'h0000, 1'b1, 1'b0, 1'b1);
    do_write(16'h0000, 1'b0, 1'b0, 1'b1);
    do_write(16'h0100, 1'b1, 1'b0, 1'b1);
    do_write(16'h9003, 1'b1, 1'b0, 1'b1);

    // Held request: second word queued while the first is scanning.
    @(negedge clk);
    a0 = acc_cnt;
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    wr_lzb   = 1'b0;
    wr_blink = 1'b0;
    sb.push_back('{hex: 16'h1234, oe: model_mask(16'h1234, 1'b0), chk_oe: 1'b1});
    @(negedge clk);
    wr_data = 16'hBEEF;
    sb.push_back('{hex: 16'hBEEF, oe: model_mask(16'hBEEF, 1'b0), chk_oe: 1'b1});
    wait_commit();
    sb_compare();
    @(negedge clk);
    wr_valid = 1'b0;
    wait_commit();
    sb_compare();
    repeat (3) @(negedge clk);
    check("held_acc_count", acc_cnt - a0, 2);
    if (acc_cyc.size() >= 2)
      check("held_acc_gap", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], DIGITS + 1);

    // Reset in the middle of a scan: the word must never reach the outputs.
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 16'hFFFF;
    wr_lzb   = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_oe", oe, 4'b0000);
    check("midrst_hex", hex_out, 16'h0000);
    check("midrst_ready", wr_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_ffff", hex_out, 16'h0000);
    end
    last_hex = 16'h0000;

    // Blink word: oe checked by pattern below rather than at commit.
    do_write(16'h0042, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      samp[i] = oe;
      @(negedge clk);
    end
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
    for (int i = 0; i < 16; i++)
      check("blink_val", (samp[i] == 4'b0011) || (samp[i] == 4'b0000), 1);
    for (int i = 4; i < 16; i++)
      check("blink_period", samp[i], (samp[i-4] == 4'b0011) ? 4'b0000 : 4'b0011);
`else
    for (int i = 0; i < 16; i++)
      check("noblink_oe", samp[i], 4'b0011);
`endif
    check("final_hex", hex_out, 16'h0042);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
